// File: rtl/fp_mul_post.sv
// Post-processing for the 4-cycle FP multiplier: per-issue operand classification held in an
// in-order tag FIFO, IEEE special-case substitution and exponent range flags. Option: FP_MUL_POST_STICKY_EN.
module fp_mul_post #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_res,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              exception,
  output logic              err
`ifdef FP_MUL_POST_STICKY_EN
  ,
  input  logic              flags_clr,
  output logic [2:0]        flags
`endif
);

  localparam int MAN_W  = DATA_W - EXP_W;
  localparam int FRAC_W = MAN_W - 1;
  localparam int BIAS   = 2**(EXP_W-1) - 1;
  localparam int SUM_W  = EXP_W + 2;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic signed [SUM_W-1:0] BIAS_S  = SUM_W'(BIAS);
  localparam logic signed [SUM_W:0]   OVF_LIM = (SUM_W+1)'(2**EXP_W - 1);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  logic             tag_sign [DEPTH];
  cls_t             tag_cls  [DEPTH];
  logic [SUM_W-1:0] tag_sum  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  cls_t              push_cls;
  logic signed [SUM_W-1:0] push_sum;

  assign ea = op_a[DATA_W-2 -: EXP_W];
  assign eb = op_b[DATA_W-2 -: EXP_W];
  assign fa = op_a[FRAC_W-1:0];
  assign fb = op_b[FRAC_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  always_comb begin
    push_cls = CLS_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      push_cls = CLS_NAN;
    else if (a_inf || b_inf)
      push_cls = CLS_INF;
    else if (a_zero || b_zero)
      push_cls = CLS_ZERO;
  end

  assign push_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  logic empty, full, do_push, do_pop, err_set;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // An empty FIFO cannot serve a pop even if a push lands in the same cycle.
  assign do_pop  = mul_done && !empty;
  assign do_push = start && (!full || mul_done);
  assign err_set = (start && full && !mul_done) || (mul_done && empty);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  logic                    rd_sign;
  cls_t                    rd_cls;
  logic signed [SUM_W-1:0] rd_sum;

  assign rd_sign = empty ? 1'b0     : tag_sign[rd_ptr];
  assign rd_cls  = empty ? CLS_NORM : tag_cls[rd_ptr];
  assign rd_sum  = empty ? '0       : tag_sum[rd_ptr];

  logic [EXP_W-1:0]        delta;
  logic signed [SUM_W:0]   true_exp;
  logic [DATA_W-1:0]       nx_res;
  logic                    nx_ovf, nx_unf, nx_exc;
  logic                    unused_mul_sign;

  assign unused_mul_sign = mul_res[DATA_W-1];
  // Multiplier exponent carries only the low EXP_W bits of the true exponent; recover the rest.
  assign delta    = mul_res[DATA_W-2 -: EXP_W] - rd_sum[EXP_W-1:0];
  assign true_exp = $signed({rd_sum[SUM_W-1], rd_sum}) + $signed({{(SUM_W+1-EXP_W){1'b0}}, delta});

  always_comb begin
    nx_res = res;
    nx_ovf = 1'b0;
    nx_unf = 1'b0;
    nx_exc = 1'b0;
    case (rd_cls)
      CLS_NAN: begin
        nx_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        nx_exc = 1'b1;
      end
      CLS_INF:  nx_res = {rd_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      CLS_ZERO: nx_res = {rd_sign, {(DATA_W-1){1'b0}}};
      default: begin
        if (true_exp >= OVF_LIM) begin
          nx_res = {rd_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          nx_ovf = 1'b1;
        end else if (true_exp <= 0) begin
          nx_res = {rd_sign, {(DATA_W-1){1'b0}}};
          nx_unf = 1'b1;
        end else begin
          nx_res = {rd_sign, mul_res[DATA_W-2:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_sign[wr_ptr] <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
      tag_cls[wr_ptr]  <= push_cls;
      tag_sum[wr_ptr]  <= push_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done      <= 1'b0;
      res       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count     <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (err_set) err <= 1'b1;
      done      <= mul_done;
      overflow  <= mul_done & nx_ovf;
      underflow <= mul_done & nx_unf;
      exception <= mul_done & nx_exc;
      if (mul_done) res <= nx_res;
    end
  end

`ifdef FP_MUL_POST_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst)
      flags <= '0;
    else
      flags <= (flags_clr ? 3'b000 : flags) | ({nx_exc, nx_ovf, nx_unf} & {3{mul_done}});
  end
`endif

endmodule

// File: tb/tb_fp_mul_post.sv
// Self-checking bench for fp_mul_post: directed cases plus randomized issue/complete streams
// checked against a queue-based reference model of the tag FIFO and IEEE result rules.
module tb_fp_mul_post;

  localparam int DEPTH = 4;

  logic        clk, rst, start, mul_done;
  logic [31:0] op_a, op_b, mul_res, res;
  logic        done, overflow, underflow, exception, err;
`ifdef FP_MUL_POST_STICKY_EN
  logic        flags_clr;
  logic [2:0]  flags;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] q[$];
  logic [31:0] exp_res;
  logic        exp_done, exp_ovf, exp_unf, exp_exc, exp_err;
  logic [2:0]  exp_flags;

  fp_mul_post #(.DATA_W(32), .EXP_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_done(mul_done), .mul_res(mul_res), .done(done), .res(res),
    .overflow(overflow), .underflow(underflow), .exception(exception), .err(err)
`ifdef FP_MUL_POST_STICKY_EN
    , .flags_clr(flags_clr), .flags(flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_calc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] mr,
                                   input bit dflt, output logic [31:0] r,
                                   output logic x, output logic o, output logic u);
    int ea, eb, sum, delta, t;
    bit az, bz, ai, bi, an, bn;
    logic sg;
    ea = a[30:23];
    eb = b[30:23];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    sg = a[31] ^ b[31];
    sum = ea + eb - 127;
    if (dflt) begin
      az = 0; bz = 0; ai = 0; bi = 0; an = 0; bn = 0; sg = 0; sum = 0;
    end
    x = 0; o = 0; u = 0;
    if (an || bn || (ai && bz) || (az && bi)) begin
      r = 32'h7FC00000; x = 1;
    end else if (ai || bi) begin
      r = {sg, 8'hFF, 23'h0};
    end else if (az || bz) begin
      r = {sg, 31'h0};
    end else begin
      delta = ((int'(mr[30:23]) - sum) % 256 + 256) % 256;
      t = sum + delta;
      if (t >= 255) begin
        r = {sg, 8'hFF, 23'h0}; o = 1;
      end else if (t <= 0) begin
        r = {sg, 31'h0}; u = 1;
      end else begin
        r = {sg, mr[30:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 7))
      0: e = 8'h00;
      1: begin e = 8'hFF; f = '0; end
      2: begin e = 8'hFF; f[0] = 1'b1; end
      3, 4: e = 8'($urandom_range(100, 160));
      5: e = 8'($urandom_range(1, 254));
      6: e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(1, 20));
    endcase
    return {s, e, f};
  endfunction

  function automatic logic [31:0] gen_mres(input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [7:0] e;
    s = int'(a[30:23]) + int'(b[30:23]) - 127 + int'($urandom_range(0, 2));
    e = 8'(((s % 256) + 256) % 256);
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; mul_done = 1'b0;
`ifdef FP_MUL_POST_STICKY_EN
    flags_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    exp_res = '0; exp_done = 0; exp_ovf = 0; exp_unf = 0; exp_exc = 0; exp_err = 0; exp_flags = '0;
  endtask

  task automatic step(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic md, input logic [31:0] mr, input logic fc);
    logic [63:0] e;
    start = s; op_a = a; op_b = b; mul_done = md; mul_res = mr;
`ifdef FP_MUL_POST_STICKY_EN
    flags_clr = fc;
`endif
    @(posedge clk);
    exp_done = md; exp_ovf = 0; exp_unf = 0; exp_exc = 0;
    if (md) begin
      if (q.size() == 0) begin
        ref_calc(32'h0, 32'h0, mr, 1'b1, exp_res, exp_exc, exp_ovf, exp_unf);
        exp_err = 1;
      end else begin
        e = q.pop_front();
        ref_calc(e[63:32], e[31:0], mr, 1'b0, exp_res, exp_exc, exp_ovf, exp_unf);
      end
    end
    if (s) begin
      if (q.size() < DEPTH) q.push_back({a, b});
      else exp_err = 1;
    end
    if (fc) exp_flags = '0;
    exp_flags = exp_flags | {exp_exc, exp_ovf, exp_unf};
    #1;
    start = 1'b0; mul_done = 1'b0;
`ifdef FP_MUL_POST_STICKY_EN
    flags_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done); errors++; end
    checks++; if (res !== 32'h0) begin $display("FAIL reset_res: got %h expected 00000000", res); errors++; end
    checks++; if (overflow !== 1'b0) begin $display("FAIL reset_ovf: got %b expected 0", overflow); errors++; end
    checks++; if (underflow !== 1'b0) begin $display("FAIL reset_unf: got %b expected 0", underflow); errors++; end
    checks++; if (exception !== 1'b0) begin $display("FAIL reset_exc: got %b expected 0", exception); errors++; end
    checks++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", err); errors++; end
  endtask

  task automatic test_directed();
    logic [31:0] ta[13], tb[13], tm[13], tr[13];
    logic [2:0]  tf[13];
    ta = '{32'h40000000, 32'h7F000000, 32'h00800000, 32'h7F800000, 32'h80000000, 32'hFF800000, 32'h7F800001,
           32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h00800000, 32'h7F000000, 32'hC0000000};
    tb = '{32'h40400000, 32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000, 32'h40000000, 32'h3F800000,
           32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h40400000};
    tm = '{32'h40C00000, 32'h3E800000, 32'h41800000, 32'h12345678, 32'h00000000, 32'h12345678, 32'h12345678,
           32'h40100000, 32'h7F800000, 32'h00400000, 32'h00800000, 32'h7F000000, 32'h40C00000};
    tr = '{32'h40C00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h80000000, 32'hFF800000, 32'h7FC00000,
           32'h40100000, 32'h7F800000, 32'h00000000, 32'h00800000, 32'h7F000000, 32'hC0C00000};
    tf = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000, 3'b100,
           3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 13; i++) begin
      step(1'b1, ta[i], tb[i], 1'b0, 32'h0, 1'b0);
      repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (done !== 1'b0) begin $display("FAIL dir%0d_early_done: got %b expected 0", i, done); errors++; end
      step(1'b0, 32'h0, 32'h0, 1'b1, tm[i], 1'b0);
      checks++;
      if ({done, res, exception, overflow, underflow, err} !== {1'b1, tr[i], tf[i], 1'b0}) begin
        $display("FAIL dir%0d_result: got done=%b res=%h exc/ovf/unf=%b err=%b expected done=1 res=%h flags=%b err=0",
                 i, done, res, {exception, overflow, underflow}, err, tr[i], tf[i]);
        errors++;
      end
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({done, res, exception, overflow, underflow} !== {1'b0, tr[i], 3'b000}) begin
        $display("FAIL dir%0d_hold: got done=%b res=%h flags=%b expected done=0 res=%h flags=000",
                 i, done, res, {exception, overflow, underflow}, tr[i]);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[4], b[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = rnd_op(); b[i] = rnd_op();
      step(1'b1, a[i], b[i], 1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, gen_mres(a[i], b[i]), 1'b0);
      checks++;
      if ({done, res, overflow, underflow, exception, err} !== {exp_done, exp_res, exp_ovf, exp_unf, exp_exc, exp_err}) begin
        $display("FAIL b2b%0d: got done=%b res=%h o/u/x=%b%b%b err=%b expected done=%b res=%h o/u/x=%b%b%b err=%b",
                 i, done, res, overflow, underflow, exception, err, exp_done, exp_res, exp_ovf, exp_unf, exp_exc, exp_err);
        errors++;
      end
    end
    checks++;
    if (err !== 1'b0) begin $display("FAIL b2b_err: got %b expected 0", err); errors++; end
  endtask

  task automatic test_full();
    logic [31:0] a[4], b[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = rnd_op(); b[i] = rnd_op();
      step(1'b1, a[i], b[i], 1'b0, 32'h0, 1'b0);
    end
    checks++;
    if (err !== 1'b0) begin $display("FAIL full_err_before: got %b expected 0", err); errors++; end
    step(1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h0, 1'b0);
    checks++;
    if (err !== 1'b1) begin $display("FAIL full_push_err: got %b expected 1", err); errors++; end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, gen_mres(a[i], b[i]), 1'b0);
      checks++;
      if ({done, res, overflow, underflow, exception} !== {exp_done, exp_res, exp_ovf, exp_unf, exp_exc}) begin
        $display("FAIL full_drain%0d: got done=%b res=%h o/u/x=%b%b%b expected done=%b res=%h o/u/x=%b%b%b",
                 i, done, res, overflow, underflow, exception, exp_done, exp_res, exp_ovf, exp_unf, exp_exc);
        errors++;
      end
    end
  endtask

  task automatic test_empty();
    apply_reset();
    step(1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40400000, 32'h40000000, 1'b0, 32'h0, 1'b0);
    apply_reset();
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'hC0C00000, 1'b0);
    checks++;
    if ({done, res, overflow, underflow, exception, err} !== {1'b1, 32'h40C00000, 3'b000, 1'b1}) begin
      $display("FAIL empty_pop: got done=%b res=%h o/u/x=%b%b%b err=%b expected done=1 res=40c00000 o/u/x=000 err=1",
               done, res, overflow, underflow, exception, err);
      errors++;
    end
    apply_reset();
    step(1'b1, 32'hC0000000, 32'h40400000, 1'b1, 32'h00000000, 1'b0);
    checks++;
    if ({done, res, underflow, err} !== {1'b1, 32'h00000000, 1'b1, 1'b1}) begin
      $display("FAIL empty_pushpop: got done=%b res=%h unf=%b err=%b expected done=1 res=00000000 unf=1 err=1",
               done, res, underflow, err);
      errors++;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h40C00000, 1'b0);
    checks++;
    if ({done, res, overflow, underflow, exception} !== {1'b1, exp_res, exp_ovf, exp_unf, exp_exc}) begin
      $display("FAIL empty_stored_tag: got done=%b res=%h o/u/x=%b%b%b expected done=1 res=%h o/u/x=%b%b%b",
               done, res, overflow, underflow, exception, exp_res, exp_ovf, exp_unf, exp_exc);
      errors++;
    end
  endtask

  task automatic test_random();
    logic        pv[4];
    logic [31:0] pa[4], pb[4];
    logic        s, md;
    logic [31:0] a, b, mr;
    apply_reset();
    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    for (int n = 0; n < 204; n++) begin
      s  = (n < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = rnd_op();
      b  = rnd_op();
      md = pv[3];
      mr = md ? gen_mres(pa[3], pb[3]) : $urandom;
      step(s, a, b, md, mr, 1'b0);
      checks++;
      if ({done, res, overflow, underflow, exception, err} !== {exp_done, exp_res, exp_ovf, exp_unf, exp_exc, exp_err}) begin
        $display("FAIL rand%0d: got done=%b res=%h o/u/x=%b%b%b err=%b expected done=%b res=%h o/u/x=%b%b%b err=%b",
                 n, done, res, overflow, underflow, exception, err, exp_done, exp_res, exp_ovf, exp_unf, exp_exc, exp_err);
        errors++;
      end
      for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; pb[k] = pb[k-1]; end
      pv[0] = s; pa[0] = a; pb[0] = b;
    end
    checks++;
    if (err !== 1'b0) begin $display("FAIL rand_err: got %b expected 0", err); errors++; end
  endtask

`ifdef FP_MUL_POST_STICKY_EN
  task automatic test_sticky();
    apply_reset();
    checks++;
    if (flags !== 3'b000) begin $display("FAIL sticky_reset: got %b expected 000", flags); errors++; end
    step(1'b1, 32'h7F000000, 32'h7F000000, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h3E800000, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (flags !== 3'b010) begin $display("FAIL sticky_ovf: got %b expected 010", flags); errors++; end
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (flags !== 3'b000) begin $display("FAIL sticky_clr: got %b expected 000", flags); errors++; end
    step(1'b1, 32'h00800000, 32'h00800000, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h41800000, 1'b1);
    checks++;
    if (flags !== 3'b001) begin $display("FAIL sticky_set_wins: got %b expected 001", flags); errors++; end
    checks++;
    if (flags !== exp_flags) begin $display("FAIL sticky_model: got %b expected %b", flags, exp_flags); errors++; end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mul_done = 1'b0; op_a = '0; op_b = '0; mul_res = '0;
`ifdef FP_MUL_POST_STICKY_EN
    flags_clr = 1'b0;
`endif
    test_reset();
    test_directed();
    test_back_to_back();
    test_full();
    test_empty();
    test_random();
`ifdef FP_MUL_POST_STICKY_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
